evt_pkt_extractor: RTL

//  Receive-side counterpart of the event-packet injector. Sits on the datapath
//  (in_*/out_*) at the collector node. Classifies each packet by EtherType,

---
 rtl/evt_pkt_extractor_pkg.sv | 28 ++
 rtl/evt_pkt_extractor_if.sv | 15 +
 rtl/fallthrough_small_fifo_old.sv | 55 +++++
 rtl/evt_pkt_extractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkt_extractor_pkg.sv
// Shared definitions for the event-packet injector/extractor pair: header
// layout, EtherType, module-header ctrl code and the extractor FSM states.
package evt_pkt_extractor_pkg;

   localparam int          DP_DATA_WIDTH      = 64;
   localparam int          DP_CTRL_WIDTH      = 8;
   localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
   localparam logic [15:0] EVT_ETYPE          = 16'h88B5;
   localparam int          EVT_HDR_WORDS      = 7;
   localparam int          EVT_PAYLOAD_WORDS  = 20;
   localparam int          IN_FIFO_DEPTH_BITS = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BUF_HDR,
      ST_REPLAY,
      ST_PASS,
      ST_EVT_HDR,
      ST_EVT_PAY,
      ST_EVT_DRAIN
   } state_t;

   // Any nonzero ctrl past the module header marks the last word of a packet.
   function automatic logic is_eop(input logic [DP_CTRL_WIDTH-1:0] ctrl);
      return ctrl != '0;
   endfunction

endpackage

// File: rtl/evt_pkt_extractor_if.sv
// Datapath word bus (data/ctrl with write strobe and ready back-pressure).
interface evt_pkt_extractor_if
   import evt_pkt_extractor_pkg::*;
#(
   parameter int DATA_WIDTH = DP_DATA_WIDTH,
   parameter int CTRL_WIDTH = DP_CTRL_WIDTH
);
   logic [DATA_WIDTH-1:0] data;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic                  wr;
   logic                  rdy;

   modport master (output data, output ctrl, output wr, input rdy);
   modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/fallthrough_small_fifo_old.sv
// Small first-word-fallthrough FIFO: dout shows the head entry whenever
// empty is low; writes while full and reads while empty are ignored.
module fallthrough_small_fifo_old #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   input  logic             reset,
   input  logic             clk
);
   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   depth_q, depth_d;
   logic                      do_wr, do_rd;

   assign full  = depth_q[MAX_DEPTH_BITS];
   assign empty = (depth_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_comb begin
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      depth_d  = depth_q;
      case ({do_wr, do_rd})
         2'b10:   depth_d = depth_q + 1'b1;
         2'b01:   depth_d = depth_q - 1'b1;
         default: depth_d = depth_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         depth_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         depth_q  <= depth_d;
      end
   end
endmodule

// File: rtl/evt_pkt_extractor.sv
// Collector-side event-packet extractor: strips event headers and writes the
// payload to the measurement FIFO; all other packets pass through unchanged.
module evt_pkt_extractor
   import evt_pkt_extractor_pkg::*;
#(
   parameter int          DATA_WIDTH        = DP_DATA_WIDTH,
   parameter int          CTRL_WIDTH        = DP_CTRL_WIDTH,
   parameter int          WORD_WIDTH        = DP_DATA_WIDTH,
   parameter int          NUM_WORDS_IN_HDR  = EVT_HDR_WORDS,
   parameter int          NUM_WORDS_PAYLOAD = EVT_PAYLOAD_WORDS,
   parameter logic [15:0] EVT_ETHERTYPE     = EVT_ETYPE
) (
   input  logic                   clk,
   input  logic                   reset_n,
   evt_pkt_extractor_if.slave     in_if,
   evt_pkt_extractor_if.master    out_if,
   output logic [WORD_WIDTH-1:0]  evt_dout,
   output logic                   evt_wr,
   input  logic                   evt_full,
   output logic                   evt_pkt_done,
   output logic                   evt_pkt_err,
   output logic [31:0]            evt_pkt_cnt
);
   localparam int FW = CTRL_WIDTH + DATA_WIDTH;

   state_t             state_q, state_d;
   logic [2:0][FW-1:0] hbuf_q, hbuf_d;
   logic [2:0]         hdr_cnt_q, hdr_cnt_d;
   logic [8:0]         pay_cnt_q, pay_cnt_d;
   logic [1:0]         len_q, len_d, rp_q, rp_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               done_q, done_d, err_q, err_d;

   logic [FW-1:0]         fifo_dout;
   logic                  fifo_empty, fifo_full, fifo_rd, fifo_avail;
   logic [CTRL_WIDTH-1:0] head_ctrl, rp_ctrl;
   logic [DATA_WIDTH-1:0] head_data;

   fallthrough_small_fifo_old #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
   ) u_in_fifo (
      .din   ({in_if.ctrl, in_if.data}),
      .wr_en (in_if.wr),
      .rd_en (fifo_rd),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .reset (~reset_n),
      .clk   (clk)
   );

   assign in_if.rdy    = ~fifo_full;
   assign fifo_avail   = ~fifo_empty;
   assign head_ctrl    = fifo_dout[FW-1:DATA_WIDTH];
   assign head_data    = fifo_dout[DATA_WIDTH-1:0];
   assign rp_ctrl      = hbuf_q[rp_q][FW-1:DATA_WIDTH];
   assign evt_pkt_done = done_q;
   assign evt_pkt_err  = err_q;
   assign evt_pkt_cnt  = cnt_q;

   always_comb begin
      state_d     = state_q;
      hbuf_d      = hbuf_q;
      hdr_cnt_d   = hdr_cnt_q;
      pay_cnt_d   = pay_cnt_q;
      len_d       = len_q;
      rp_d        = rp_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      fifo_rd     = 1'b0;
      out_if.data = '0;
      out_if.ctrl = '0;
      out_if.wr   = 1'b0;
      evt_wr      = 1'b0;
      evt_dout    = '0;

      case (state_q)
         // Words ahead of a module header belong to no packet and are dropped.
         ST_IDLE: begin
            if (fifo_avail) begin
               fifo_rd = 1'b1;
               if (head_ctrl == IO_QUEUE_STAGE_NUM) begin
                  hbuf_d[0] = fifo_dout;
                  hdr_cnt_d = 3'd1;
                  state_d   = ST_BUF_HDR;
               end
            end
         end

         ST_BUF_HDR: begin
            if (fifo_avail) begin
               fifo_rd                 = 1'b1;
               hbuf_d[hdr_cnt_q[1:0]] = fifo_dout;
               rp_d                    = 2'd0;
               if (is_eop(head_ctrl)) begin
                  len_d   = hdr_cnt_q[1:0] + 2'd1;
                  state_d = ST_REPLAY;
               end else if (hdr_cnt_q == 3'd2) begin
                  len_d = 2'd3;
                  if (head_data[31:16] == EVT_ETHERTYPE) begin
                     hdr_cnt_d = 3'd3;
                     state_d   = ST_EVT_HDR;
                  end else begin
                     state_d = ST_REPLAY;
                  end
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 3'd1;
               end
            end
         end

         ST_REPLAY: begin
            if (out_if.rdy) begin
               out_if.wr   = 1'b1;
               out_if.data = hbuf_q[rp_q][DATA_WIDTH-1:0];
               out_if.ctrl = rp_ctrl;
               if (rp_q == len_q - 2'd1)
                  state_d = is_eop(rp_ctrl) ? ST_IDLE : ST_PASS;
               else
                  rp_d = rp_q + 2'd1;
            end
         end

         ST_PASS: begin
            if (fifo_avail && out_if.rdy) begin
               fifo_rd     = 1'b1;
               out_if.wr   = 1'b1;
               out_if.data = head_data;
               out_if.ctrl = head_ctrl;
               if (is_eop(head_ctrl)) state_d = ST_IDLE;
            end
         end

         ST_EVT_HDR: begin
            if (fifo_avail) begin
               fifo_rd = 1'b1;
               if (is_eop(head_ctrl)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (hdr_cnt_q == 3'(NUM_WORDS_IN_HDR - 1)) begin
                  pay_cnt_d = '0;
                  state_d   = ST_EVT_PAY;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 3'd1;
               end
            end
         end

         // Words already handed to the measurement FIFO stay there on error.
         ST_EVT_PAY: begin
            if (fifo_avail && !evt_full) begin
               fifo_rd  = 1'b1;
               evt_wr   = 1'b1;
               evt_dout = WORD_WIDTH'(head_data);
               if (pay_cnt_q == 9'(NUM_WORDS_PAYLOAD - 1)) begin
                  if (is_eop(head_ctrl)) begin
                     done_d  = 1'b1;
                     cnt_d   = cnt_q + 32'd1;
                     state_d = ST_IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_EVT_DRAIN;
                  end
               end else if (is_eop(head_ctrl)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pay_cnt_d = pay_cnt_q + 9'd1;
               end
            end
         end

         ST_EVT_DRAIN: begin
            if (fifo_avail) begin
               fifo_rd = 1'b1;
               if (is_eop(head_ctrl)) state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         hbuf_q    <= '0;
         hdr_cnt_q <= '0;
         pay_cnt_q <= '0;
         len_q     <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hbuf_q    <= hbuf_d;
         hdr_cnt_q <= hdr_cnt_d;
         pay_cnt_q <= pay_cnt_d;
         len_q     <= len_d;
         rp_q      <= rp_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end
endmodule
